// File: rtl/jpeg_idct_ctrl.sv
// Sequencer around a combinational 8x8 IDCT: gathers 64 coefficients, lets the IDCT settle,
// captures and level-shifts its result, then streams 64 clamped pixels out under valid/ready.
module jpeg_idct_ctrl #(
  parameter int unsigned IDCT_LATENCY = 2,
  parameter int unsigned DESCALE      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic [15:0]   coef_data,
  output logic [1023:0] idct_in_flat,
  input  logic [1023:0] idct_out_flat,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [7:0]    pix_data,
  output logic          pix_last,
  output logic          busy,
  output logic          blk_done
);

  typedef enum logic [1:0] {StLoad, StSettle, StOut} state_e;

  localparam logic signed [17:0] Round    = 18'((1 << DESCALE) >> 1);
  localparam logic [3:0]         WaitInit = 4'(IDCT_LATENCY - 1);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  wait_q, wait_d;
  logic        blk_done_q, blk_done_d;
  logic        coef_we, capture;
  logic        coef_hs, pix_hs;
  logic [15:0] coef_q [64];
  logic [7:0]  pix_q  [64];

  // Descale with round-half-up, level shift, clamp to 0..255; 18 bits cannot overflow.
  function automatic logic [7:0] to_pixel(input logic [15:0] x);
    logic signed [17:0] t;
    logic [7:0]         p;
    t = {{2{x[15]}}, x};
    t = (t + Round) >>> DESCALE;
    t = t + 18'sd128;
    if (t < 18'sd0) begin
      p = 8'd0;
    end else if (t > 18'sd255) begin
      p = 8'd255;
    end else begin
      p = t[7:0];
    end
    return p;
  endfunction

  // The block is held off for the blk_done cycle so a new block never overlaps the old one.
  assign coef_ready = (state_q == StLoad) && !blk_done_q;
  assign pix_valid  = (state_q == StOut);
  assign pix_data   = pix_q[idx_q];
  assign pix_last   = pix_valid && (idx_q == 6'd63);
  assign busy       = !((state_q == StLoad) && (idx_q == 6'd0));
  assign blk_done   = blk_done_q;
  assign coef_hs    = coef_valid && coef_ready;
  assign pix_hs     = pix_valid && pix_ready;

  always_comb begin
    idct_in_flat = '0;
    for (int k = 0; k < 64; k++) begin
      idct_in_flat[16*k +: 16] = coef_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    blk_done_d = 1'b0;
    coef_we    = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (coef_hs) begin
          coef_we = 1'b1;
          if (idx_q == 6'd63) begin
            idx_d   = 6'd0;
            wait_d  = WaitInit;
            state_d = StSettle;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      StSettle: begin
        if (wait_q == 4'd0) begin
          capture = 1'b1;
          state_d = StOut;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StOut: begin
        if (pix_hs) begin
          if (idx_q == 6'd63) begin
            idx_d      = 6'd0;
            blk_done_d = 1'b1;
            state_d    = StLoad;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      idx_q      <= 6'd0;
      wait_q     <= 4'd0;
      blk_done_q <= 1'b0;
      for (int k = 0; k < 64; k++) begin
        coef_q[k] <= 16'd0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      blk_done_q <= blk_done_d;
      if (coef_we) begin
        coef_q[idx_q] <= coef_data;
      end
    end
  end

  // Pixel buffer is only ever read after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < 64; k++) begin
        pix_q[k] <= to_pixel(idct_out_flat[16*k +: 16]);
      end
    end
  end

endmodule

// File: tb/tb_jpeg_idct_ctrl.sv
// Bench for jpeg_idct_ctrl: fixed pixel tables, random blocks against a floor-division
// reference, backpressure, back-to-back blocks and a mid-block reset.
module tb_jpeg_idct_ctrl;
  localparam int unsigned L = 2;
  localparam int unsigned D = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          coef_valid;
  logic          coef_ready;
  logic [15:0]   coef_data;
  logic [1023:0] idct_in_flat;
  logic [1023:0] idct_out_flat;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          pix_last;
  logic          busy;
  logic          blk_done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int hs_cyc = 0;

  logic signed [15:0] coefs [64];
  logic signed [15:0] bias  [64];
  int                 expv  [64];

  typedef struct {
    int x;
    int e;
  } vec_t;
  vec_t vecs [14];

  jpeg_idct_ctrl #(
    .IDCT_LATENCY(L),
    .DESCALE     (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_data    (coef_data),
    .idct_in_flat (idct_in_flat),
    .idct_out_flat(idct_out_flat),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .busy         (busy),
    .blk_done     (blk_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in IDCT: input element plus a per-element bias chosen by each test.
  always_comb begin
    idct_out_flat = '0;
    for (int k = 0; k < 64; k++) begin
      idct_out_flat[16*k +: 16] = idct_in_flat[16*k +: 16] + bias[k];
    end
  end

  function automatic int pix_ref(input int x);
    int p;
    int n;
    int t;
    p = 1 << D;
    n = x + p / 2;
    if (n >= 0) t = n / p;
    else        t = -((-n + p - 1) / p);
    t = t + 128;
    if (t < 0)   t = 0;
    if (t > 255) t = 255;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setup_rand();
    for (int k = 0; k < 64; k++) begin
      coefs[k] = 16'(int'($urandom_range(0, 8000)) - 4000);
      bias[k]  = 16'(int'($urandom_range(0, 600)) - 300);
      expv[k]  = pix_ref(int'(coefs[k]) + int'(bias[k]));
    end
  endtask

  task automatic send_block(input bit hold);
    int tmo;
    for (int i = 0; i < 64; i++) begin
      tmo = 0;
      coef_valid = 1'b1;
      coef_data  = coefs[i];
      while (!coef_ready && tmo < 300) begin
        @(negedge clk);
        tmo++;
      end
      if (!coef_ready) begin
        chk("coef_accept_timeout", 0, 1);
        coef_valid = 1'b0;
        return;
      end
      hs_cyc = cyc;
      @(negedge clk);
      chk("busy_after_coef", int'(busy), 1);
    end
    if (!hold) coef_valid = 1'b0;
  endtask

  task automatic recv_block(input bit rnd, input bit chk_lat, input int stop_at);
    int         i;
    int         tmo;
    bit         stalled;
    bit         first;
    logic [7:0] sd;
    logic       sl;
    i = 0;
    tmo = 0;
    stalled = 1'b0;
    first = 1'b1;
    sd = 8'd0;
    sl = 1'b0;
    while (i < 64 && tmo < 3000) begin
      if (pix_valid) begin
        if (first && chk_lat) chk("first_pix_latency", cyc - hs_cyc, L + 1);
        first = 1'b0;
        if (i == stop_at) begin
          pix_ready = 1'b0;
          return;
        end
        chk("coef_ready_low_out", int'(coef_ready), 0);
        chk("blk_done_low_out", int'(blk_done), 0);
        if (stalled) begin
          chk("stall_data_hold", int'(pix_data), int'(sd));
          chk("stall_last_hold", int'(pix_last), int'(sl));
        end
        pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pix_ready) begin
          chk($sformatf("pix[%0d]", i), int'(pix_data), expv[i]);
          chk("pix_last", int'(pix_last), int'(i == 63));
          i++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sd = pix_data;
          sl = pix_last;
        end
      end else begin
        chk("coef_ready_low_settle", int'(coef_ready), 0);
      end
      @(negedge clk);
      tmo++;
    end
    if (i < 64) begin
      chk("pix_timeout", i, 64);
    end else begin
      chk("blk_done_pulse", int'(blk_done), 1);
      chk("pix_valid_drop", int'(pix_valid), 0);
      chk("coef_ready_during_done", int'(coef_ready), 0);
      @(negedge clk);
      chk("blk_done_single", int'(blk_done), 0);
      chk("coef_ready_after_done", int'(coef_ready), 1);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_coef_ready"}, int'(coef_ready), 1);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_pix_last"}, int'(pix_last), 0);
    chk({tag, "_blk_done"}, int'(blk_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_idct_in_zero"}, int'(idct_in_flat == '0), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{'{0, 128}, '{4, 129}, '{-5, 127}, '{4000, 255}, '{-4000, 0}, '{1020, 255},
             '{-1028, 0}, '{3, 128}, '{-4, 128}, '{12, 130}, '{1011, 254}, '{-1020, 1},
             '{32767, 255}, '{-32768, 0}};
    rst = 1'b1;
    coef_valid = 1'b0;
    coef_data = 16'd0;
    pix_ready = 1'b0;
    for (int k = 0; k < 64; k++) bias[k] = 16'sd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // All-zero block.
    for (int k = 0; k < 64; k++) begin
      coefs[k] = 16'sd0;
      bias[k]  = 16'sd0;
      expv[k]  = 128;
    end
    send_block(1'b0);
    recv_block(1'b0, 1'b1, 64);

    // Ramp: element k returns 8*(k-64).
    for (int k = 0; k < 64; k++) begin
      bias[k] = 16'(8 * (k - 64));
      expv[k] = 64 + k;
    end
    send_block(1'b0);
    recv_block(1'b0, 1'b0, 64);

    // Clamp and rounding table.
    for (int k = 0; k < 64; k++) begin
      bias[k] = 16'(vecs[k % 14].x);
      expv[k] = vecs[k % 14].e;
    end
    send_block(1'b0);
    recv_block(1'b0, 1'b0, 64);

    // Random blocks under random backpressure.
    for (int b = 0; b < 3; b++) begin
      setup_rand();
      send_block(1'b0);
      recv_block(1'b1, 1'b0, 64);
    end

    // Back-to-back with coef_valid held high across the drain.
    setup_rand();
    send_block(1'b1);
    recv_block(1'b0, 1'b0, 64);
    setup_rand();
    send_block(1'b0);
    recv_block(1'b0, 1'b0, 64);

    // Reset at pixel 20, then a fresh full block.
    setup_rand();
    send_block(1'b0);
    recv_block(1'b1, 1'b0, 20);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midreset");
    rst = 1'b0;
    setup_rand();
    send_block(1'b0);
    recv_block(1'b1, 1'b0, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_idct_ctrl.md
Name: jpeg_idct_ctrl

Overview:
Sequencer wrapped around the combinational 8x8 two-dimensional IDCT datapath.
- Collects 64 dequantized coefficients (natural row-major order) from a valid/ready stream into an 8x8 buffer.
- Presents the buffer to the external IDCT and waits a programmable settle time.
- Captures the IDCT result, then applies descale, +128 level shift and 0..255 clamp.
- Streams 64 pixels out under valid/ready.
- Sits between the dequantizer and the colour-conversion/MCU buffer stage.

Parameters:
- IDCT_LATENCY, 2, cycles between driving idct_in_flat and sampling idct_out_flat (1..15).
- DESCALE, 3, arithmetic right shift applied to each IDCT output before level shift (0..7).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- coef_valid  in  1  coefficient present
- coef_ready  out  1  block accepts coefficient
- coef_data  in  16  signed coefficient
- idct_in_flat  out  1024  64x16 buffer to IDCT; element k = bits [16k+15:16k], k = row*8+col
- idct_out_flat  in  1024  64x16 signed IDCT result, same packing
- pix_valid  out  1  pixel present
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  8  unsigned pixel
- pix_last  out  1  high with pixel 63 of a block
- busy  out  1  high in any state other than LOAD with count 0
- blk_done  out  1  one-cycle pulse after pixel 63 handshake

Behaviour:
One clock domain (clk). Reset is synchronous and active-high (rst). All transfers occur on a rising edge where valid and ready are both high.

Reset values:
- State is LOAD; coefficient index = 0.
- coef_ready = 1.
- pix_valid = 0, pix_last = 0, blk_done = 0, busy = 0.
- Coefficient buffer is cleared to 0, so idct_in_flat = 0.

States:
- LOAD
  - coef_ready = 1.
  - Each coefficient handshake writes buffer[idx] and increments idx.
  - On the handshake with idx = 63: clear idx, go to SETTLE, load the wait counter with IDCT_LATENCY-1.
  - coef_ready drops the cycle after the 64th handshake.
- SETTLE
  - coef_ready = 0; the buffer is frozen.
  - Wait counter decrements each cycle.
  - When the counter is 0: register all 64 IDCT outputs into the pixel buffer, then go to OUT.
  - Total: the IDCT input is stable for exactly IDCT_LATENCY cycles before capture.
- OUT
  - pix_valid = 1; pix_data = pixel buffer[idx], idx starting at 0.
  - Each pixel handshake increments idx.
  - pix_last = 1 when idx = 63.
  - On the handshake at idx = 63:
    - pix_valid drops next cycle.
    - blk_done pulses next cycle.
    - idx clears; return to LOAD.
  - When pix_ready = 0, pix_data and pix_last hold stable.

Pixel arithmetic, per element x (signed 16):
- If DESCALE > 0: t = (x + 2^(DESCALE-1)) >>> DESCALE, computed in 18 bits (no overflow). If DESCALE = 0: t = x.
- u = t + 128.
- Clamp u to the range 0..255.

Boundaries:
- coef_valid while in SETTLE or OUT is ignored; the upstream must hold it.
- A new block cannot be loaded while OUT is draining; single-buffered by design.
- The first coefficient of the next block is accepted no earlier than the cycle after blk_done.
- The buffer is overwritten in place, so no clear between blocks is needed.
- rst mid-LOAD, mid-SETTLE or mid-OUT: return to reset values on the next edge; any partial block is discarded with no pix_valid glitch.
- pix_ready held low indefinitely: state holds; no pixel is lost or duplicated.
- Pixel order out matches the row-major order of idct_out_flat.

Test Plan:
1. All-zero block, pix_ready = 1 → 64 pixels of 128; pix_last on the 64th; one blk_done pulse. First pix_valid rises IDCT_LATENCY+1 cycles after the 64th coefficient handshake.
2. Testbench IDCT model returns 8*(k-64) for element k, DESCALE = 3 → pixel k = 64+k for k = 0..63, i.e. pixels 64..127.
3. Clamp: model outputs +4000 / -4000 / +1020 / -1028 → pixels 255 / 0 / 255 / 0. Rounding checks, DESCALE = 3: +4 → 129; -5 → 127.
4. Backpressure: pix_ready toggles 1,0,0,1 randomly → exactly 64 distinct in-order pixels. pix_data stays stable while stalled, and coef_ready stays 0 until after blk_done.
5. Back-to-back blocks with coef_valid held high → coef_ready low from the cycle after coefficient 63 until after blk_done. Second block output is correct and not corrupted by the first.
6. Assert rst for one cycle at pixel 20 of a block → pix_valid = 0 and coef_ready = 1 next cycle. A fresh block then produces a full 64-pixel output.
